addsub_pipe: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath. It replaces the fixed 16-bit combinational adder with a WIDTH-bit unit that splits the operands into SEG-bit lookahead slices, one slice per pipeline stage. It supports ADD/SUB/ADC/SBC, produces C/V/Z/N flags, and uses a valid/ready handshake with a passthrough tag so the issue logic can track results.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/cla_slice.sv | 41 ++++
 rtl/addsub_pipe.sv | 168 ++++++++++++++++
 tb/tb_addsub_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types: opcode encoding, flag bundle and carry-in constants.
// Used by the adder/subtractor, the ALU top and the bench.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_ADC = 2'b10,
    ALU_SBC = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic n;
  } alu_flags_t;

  localparam logic CIN_ADD = 1'b0;
  localparam logic CIN_SUB = 1'b1;

endpackage

// File: rtl/cla_slice.sv
// Combinational SEG-bit carry-lookahead slice. Each carry is formed directly
// from generate/propagate terms and the slice carry-in.
module cla_slice #(
  parameter int unsigned SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb_in
);

  logic [SEG-1:0] g;
  logic [SEG-1:0] p;
  logic [SEG:0]   c;
  logic           prod;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    prod = 1'b0;
    c[0] = cin;
    // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]cin
    for (int i = 0; i < int'(SEG); i++) begin
      c[i+1] = g[i];
      prod   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prod & g[j]);
        prod   = prod & p[j];
      end
      c[i+1] = c[i+1] | (prod & cin);
    end
    sum = p ^ c[SEG-1:0];
  end

  assign cout     = c[SEG];
  assign c_msb_in = c[SEG-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one SEG-bit slice per stage,
// global stall flow control, tag carried alongside each operation.
module addsub_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_e          in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output alu_flags_t       out_flags,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned SEG_SAFE = (SEG >= 1) ? SEG : 1;
  localparam int unsigned STAGES   = (WIDTH / SEG_SAFE >= 1) ? WIDTH / SEG_SAFE : 1;

  if (SEG < 1 || (WIDTH % SEG_SAFE) != 0) begin : gen_cfg_check
    $fatal(1, "addsub_pipe: WIDTH (%0d) must be a non-zero multiple of SEG (%0d)", WIDTH, SEG);
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin0;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    b_eff = in_b;
    cin0  = CIN_ADD;
    unique case (in_op)
      ALU_ADD: begin
        b_eff = in_b;
        cin0  = CIN_ADD;
      end
      ALU_SUB: begin
        b_eff = ~in_b;
        cin0  = CIN_SUB;
      end
      ALU_ADC: begin
        b_eff = in_b;
        cin0  = in_cin;
      end
      ALU_SBC: begin
        b_eff = ~in_b;
        cin0  = in_cin;
      end
    endcase
  end

  for (genvar s = 0; s < STAGES; s++) begin : gen_stage
    // Operand bits not yet consumed, starting at bit s*SEG.
    localparam int unsigned RI = WIDTH - s * SEG;
    localparam int unsigned SW = (s + 1) * SEG;

    logic             vld_q;
    logic             cy_q;
    logic             zero_q;
    logic [SW-1:0]    sum_q;
    logic [TAG_W-1:0] tag_q;

    logic             v_in;
    logic             c_in;
    logic             z_in;
    logic [RI-1:0]    a_in;
    logic [RI-1:0]    b_in;
    logic [TAG_W-1:0] tag_in;
    logic [SW-1:0]    sum_nx;
    logic [SEG-1:0]   sl_sum;
    logic             sl_cout;
    logic             sl_cmsb;

    if (s == 0) begin : gen_head
      assign v_in   = in_valid;
      assign c_in   = cin0;
      assign z_in   = 1'b1;
      assign a_in   = in_a;
      assign b_in   = b_eff;
      assign tag_in = in_tag;
      assign sum_nx = sl_sum;
    end else begin : gen_body
      assign v_in   = gen_stage[s-1].vld_q;
      assign c_in   = gen_stage[s-1].cy_q;
      assign z_in   = gen_stage[s-1].zero_q;
      assign a_in   = gen_stage[s-1].gen_fwd.a_q;
      assign b_in   = gen_stage[s-1].gen_fwd.b_q;
      assign tag_in = gen_stage[s-1].tag_q;
      assign sum_nx = {sl_sum, gen_stage[s-1].sum_q};
    end

    cla_slice #(
      .SEG(SEG)
    ) u_slice (
      .a       (a_in[SEG-1:0]),
      .b       (b_in[SEG-1:0]),
      .cin     (c_in),
      .sum     (sl_sum),
      .cout    (sl_cout),
      .c_msb_in(sl_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        cy_q   <= 1'b0;
        zero_q <= 1'b0;
        sum_q  <= '0;
        tag_q  <= '0;
      end else if (advance) begin
        vld_q  <= v_in;
        cy_q   <= sl_cout;
        zero_q <= z_in & ~|sl_sum;
        sum_q  <= sum_nx;
        tag_q  <= tag_in;
      end
    end

    if (s < STAGES - 1) begin : gen_fwd
      logic [RI-SEG-1:0] a_q;
      logic [RI-SEG-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_in[RI-1:SEG];
          b_q <= b_in[RI-1:SEG];
        end
      end
    end

    if (s == STAGES - 1) begin : gen_tail
      logic cmsb_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cmsb_q <= 1'b0;
        end else if (advance) begin
          cmsb_q <= sl_cmsb;
        end
      end
    end
  end

  assign out_valid = gen_stage[STAGES-1].vld_q;
  assign out_sum   = gen_stage[STAGES-1].sum_q;
  assign out_tag   = gen_stage[STAGES-1].tag_q;
  assign out_flags = '{
    c: gen_stage[STAGES-1].cy_q,
    v: gen_stage[STAGES-1].gen_tail.cmsb_q ^ gen_stage[STAGES-1].cy_q,
    z: gen_stage[STAGES-1].zero_q,
    n: gen_stage[STAGES-1].sum_q[WIDTH-1]
  };

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: directed corner cases, a stalled random stream, mid-flight
// reset and a 32-bit instance, all checked against an arithmetic reference model.
module tb_addsub_pipe;
  import alu_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned TW = 4;

  typedef struct packed {
    logic [W-1:0]  sum;
    alu_flags_t    fl;
    logic [TW-1:0] tag;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_cin, out_valid, out_ready;
  alu_op_e       in_op;
  logic [W-1:0]  in_a, in_b, out_sum;
  logic [TW-1:0] in_tag, out_tag;
  alu_flags_t    out_flags;

  logic [31:0]   a32, b32, sum32;
  alu_flags_t    flags32;
  logic [TW-1:0] tag32;
  logic          ov32, ir32;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(W), .SEG(4), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_flags(out_flags), .out_tag(out_tag)
  );

  addsub_pipe #(.WIDTH(32), .SEG(8), .TAG_W(TW)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32), .in_op(in_op),
    .in_a(a32), .in_b(b32), .in_cin(in_cin), .in_tag(in_tag), .out_valid(ov32),
    .out_ready(out_ready), .out_sum(sum32), .out_flags(flags32), .out_tag(tag32)
  );

  // Reference: integer add/subtract with explicit signed-range overflow test.
  function automatic res_t model(alu_op_e op, logic [W-1:0] a, logic [W-1:0] b, logic cin,
                                 logic [TW-1:0] tag);
    longint ua, ub, sa, sb, k, ur, sr;
    logic [63:0] urv;
    res_t r;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    k  = 0;
    case (op)
      ALU_ADC: k = longint'(cin);
      ALU_SBC: k = longint'(!cin);
      default: k = 0;
    endcase
    if (op == ALU_ADD || op == ALU_ADC) begin
      ur = ua + ub + k;
      sr = sa + sb + k;
      r.fl.c = (ur >= (longint'(1) << W));
    end else begin
      ur = ua - ub - k;
      sr = sa - sb - k;
      r.fl.c = (ur >= 0);
    end
    urv    = ur;
    r.sum  = urv[W-1:0];
    r.fl.v = (sr > ((longint'(1) << (W - 1)) - 1)) || (sr < -(longint'(1) << (W - 1)));
    r.fl.z = (r.sum == '0);
    r.fl.n = r.sum[W-1];
    r.tag  = tag;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic drive_rand(input logic [TW-1:0] tag);
    in_valid = 1'b1;
    in_op    = alu_op_e'($urandom_range(3, 0));
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    in_cin   = 1'($urandom);
    in_tag   = tag;
  endtask

  // Called at a falling edge; one op, then waits for its result with out_ready high.
  task automatic single_op(input string name, input alu_op_e op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic cin, input logic [TW-1:0] tag,
                           input logic [W-1:0] es, input logic [3:0] ef);
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    in_tag    = tag;
    #1;
    chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    chk({name, "_latency"}, 64'(n), 64'd4);
    chk({name, "_sum"}, 64'(out_sum), 64'(es));
    chk({name, "_flags"}, 64'(out_flags), 64'(ef));
    chk({name, "_tag"}, 64'(out_tag), 64'(tag));
  endtask

  initial begin
    res_t          q[$];
    res_t          exp_r;
    res_t          prev;
    logic          prev_stalled;
    logic          accepting;
    int            cyc, sent, got, stall_lo, ghost, n;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = ALU_ADD;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
    a32       = '0;
    b32       = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_flags", 64'(out_flags), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // First op is offered on the very first edge after release.
    rst_n = 1'b1;
    single_op("add_basic", ALU_ADD, 16'h1234, 16'h4321, 1'b0, 4'd1, 16'h5555, 4'b0000);
    single_op("add_wrap", ALU_ADD, 16'hFFFF, 16'h0001, 1'b0, 4'd2, 16'h0000, 4'b1010);
    single_op("adc_ovf", ALU_ADC, 16'h7FFF, 16'h0000, 1'b1, 4'd3, 16'h8000, 4'b0101);
    single_op("sub_neg", ALU_SUB, 16'h0005, 16'h0007, 1'b0, 4'd4, 16'hFFFE, 4'b0001);
    single_op("sub_ovf", ALU_SUB, 16'h8000, 16'h0001, 1'b0, 4'd5, 16'h7FFF, 4'b1100);
    single_op("sbc_brw", ALU_SBC, 16'h0010, 16'h0001, 1'b0, 4'd6, 16'h000E, 4'b1000);

    // 32-bit instance with 8-bit slices.
    in_valid = 1'b1;
    in_op    = ALU_ADD;
    in_cin   = 1'b0;
    in_tag   = 4'd9;
    a32      = 32'hFFFF_FFFF;
    b32      = 32'h0000_0001;
    #1 chk("w32_in_ready", 64'(ir32), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (ov32) break;
    end
    chk("w32_latency", 64'(n), 64'd4);
    chk("w32_sum", 64'(sum32), 64'd0);
    chk("w32_flags", 64'(flags32), 64'(4'b1010));
    chk("w32_tag", 64'(tag32), 64'd9);
    repeat (2) @(negedge clk);

    // Back-to-back stream of 8 with a 3-cycle output stall.
    cyc          = 0;
    sent         = 0;
    got          = 0;
    stall_lo     = 0;
    prev_stalled = 1'b0;
    prev         = '0;
    drive_rand(4'd0);
    while (got < 8 && cyc < 60) begin
      out_ready = !(cyc >= 6 && cyc <= 8);
      #1;
      chk("stream_in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (prev_stalled) begin
        chk("stall_hold_valid", 64'(out_valid), 64'd1);
        chk("stall_hold_sum", 64'(out_sum), 64'(prev.sum));
        chk("stall_hold_flags", 64'(out_flags), 64'(prev.fl));
        chk("stall_hold_tag", 64'(out_tag), 64'(prev.tag));
      end
      prev_stalled = out_valid && !out_ready;
      prev         = '{sum: out_sum, fl: out_flags, tag: out_tag};
      if (prev_stalled) stall_lo++;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("stream_unexpected", 64'(out_tag), 64'hDEAD);
        end else begin
          exp_r = q.pop_front();
          chk("stream_sum", 64'(out_sum), 64'(exp_r.sum));
          chk("stream_flags", 64'(out_flags), 64'(exp_r.fl));
          chk("stream_tag", 64'(out_tag), 64'(exp_r.tag));
        end
        got++;
      end
      accepting = in_valid && in_ready;
      if (accepting) begin
        q.push_back(model(in_op, in_a, in_b, in_cin, in_tag));
        sent++;
      end
      @(posedge clk);
      #1;
      if (accepting) begin
        if (sent < 8) drive_rand(TW'(sent));
        else in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk("stream_count", 64'(got), 64'd8);
    chk("stream_leftover", 64'(q.size()), 64'd0);
    chk("stall_cycles", 64'(stall_lo), 64'd3);

    // Reset with ops in flight, result held at the output.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand(TW'(i + 10));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #2 chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_sum", 64'(out_sum), 64'd0);
    chk("midrst_out_flags", 64'(out_flags), 64'd0);
    chk("midrst_out_tag", 64'(out_tag), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    ghost     = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) ghost++;
    end
    chk("post_rst_ghosts", 64'(ghost), 64'd0);

    for (int i = 0; i < 4; i++) begin
      drive_rand(TW'(i));
      exp_r = model(in_op, in_a, in_b, in_cin, in_tag);
      single_op("post_rst_rand", in_op, in_a, in_b, in_cin, in_tag, exp_r.sum, 4'(exp_r.fl));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
